// File: rtl/dac_sample_streamer.sv
// Purpose: buffers AXI-Stream I/Q samples in a FIFO and replays them to the DAC at one sample per RATE_DIV clocks.
// Latency: one cycle from a rate tick to dac_valid; streaming waits for PREFILL samples or an input gap of IDLE_TIMEOUT.
// Backpressure: s_axis_tready is low only while the FIFO is full; acceptance is independent of enable.
module dac_sample_streamer #(
   parameter int DEPTH        = 64,
   parameter int PREFILL      = 16,
   parameter int RATE_DIV     = 4,
   parameter int IDLE_TIMEOUT = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic [31:0]                  s_axis_tdata,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   output logic [15:0]                  dac_i,
   output logic [15:0]                  dac_q,
   output logic                         dac_valid,
   output logic                         underrun,
   input  logic                         underrun_clr,
   output logic [15:0]                  underrun_count,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
   output logic                         active
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int DW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
   localparam int GW = $clog2(IDLE_TIMEOUT + 1);

   localparam logic [LW-1:0] LVL_FULL    = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_PREFILL = LW'(PREFILL);
   localparam logic [DW-1:0] DIV_LAST    = DW'(RATE_DIV - 1);
   localparam logic [GW-1:0] GAP_MAX     = GW'(IDLE_TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PREFILL = 2'd1,
      ST_STREAM  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [31:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [GW-1:0]   gap_cnt;
   logic [DW-1:0]   div_cnt;
   logic [31:0]     head_dat;
   logic            push_vld;
   logic            pop_vld;
   logic            tick;
   logic            starve;

   assign s_axis_tready = (fifo_level != LVL_FULL);
   assign push_vld      = s_axis_tvalid && s_axis_tready;
   assign head_dat      = mem[rd_ptr];
   assign tick          = (state == ST_STREAM) && (div_cnt == DIV_LAST);
   assign pop_vld       = tick && (fifo_level != '0);
   assign starve        = tick && (fifo_level == '0);

   // Next-state logic; dropping enable returns to IDLE from anywhere.
   always_comb begin
      state_nxt = state;
      if (!enable) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (fifo_level != '0) state_nxt = ST_PREFILL;
            end
            ST_PREFILL: begin
               if (fifo_level == '0)
                  state_nxt = ST_IDLE;
               else if ((fifo_level >= LVL_PREFILL) || (gap_cnt == GAP_MAX))
                  state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
               if (starve) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst_n) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Sample storage; contents need no reset because the level gates every read.
   always_ff @(posedge clk) begin
      if (push_vld) mem[wr_ptr] <= s_axis_tdata;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push_vld) wr_ptr <= wr_ptr + AW'(1);
         if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_vld, pop_vld})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Input gap timer: restarts on any accepted sample or state change, saturates at the timeout.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         gap_cnt <= '0;
      end else if (push_vld || (state_nxt != state)) begin
         gap_cnt <= '0;
      end else if (gap_cnt != GAP_MAX) begin
         gap_cnt <= gap_cnt + GW'(1);
      end
   end

   // Rate divider; preloaded on STREAM entry so the first tick lands in the first STREAM cycle.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         div_cnt <= '0;
      end else if ((state != ST_STREAM) && (state_nxt == ST_STREAM)) begin
         div_cnt <= DIV_LAST;
      end else if (tick) begin
         div_cnt <= '0;
      end else if (state == ST_STREAM) begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   // DAC output register: head sample on a tick, zero sample on starvation, zero on enable drop.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         dac_i     <= '0;
         dac_q     <= '0;
         dac_valid <= 1'b0;
      end else if (tick) begin
         dac_valid <= 1'b1;
         if (starve) begin
            dac_i <= '0;
            dac_q <= '0;
         end else begin
            dac_i <= head_dat[31:16];
            dac_q <= head_dat[15:0];
         end
      end else begin
         dac_valid <= 1'b0;
         if ((state == ST_STREAM) && !enable) begin
            dac_i <= '0;
            dac_q <= '0;
         end
      end
   end

   // Sticky underrun flag and saturating counter; a new underrun beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         underrun       <= 1'b0;
         underrun_count <= '0;
      end else if (starve) begin
         underrun <= 1'b1;
         if (underrun_clr)
            underrun_count <= 16'd1;
         else if (underrun_count != 16'hFFFF)
            underrun_count <= underrun_count + 16'd1;
      end else if (underrun_clr) begin
         underrun       <= 1'b0;
         underrun_count <= '0;
      end
   end

   // Registered copy of the STREAM state.
   always_ff @(posedge clk) begin
      if (rst_n) active <= 1'b0;
      else       active <= (state_nxt == ST_STREAM);
   end

endmodule

// File: tb/tb_dac_sample_streamer.sv
module tb_dac_sample_streamer;

   logic clk;
   int   n_total;
   int   n_pass;
   int   n_fail;

   // Instance A: default parameters.
   logic        a_rst, a_en, a_tvalid, a_tready, a_dac_valid, a_underrun, a_clr, a_active;
   logic [31:0] a_tdata;
   logic [15:0] a_dac_i, a_dac_q, a_cnt;
   logic [6:0]  a_level;

   // Instance B: one sample per clock, prefill of 5.
   logic        b_rst, b_en, b_tvalid, b_tready, b_dac_valid, b_underrun, b_clr, b_active;
   logic [31:0] b_tdata;
   logic [15:0] b_dac_i, b_dac_q, b_cnt;
   logic [6:0]  b_level;

   dac_sample_streamer #(.DEPTH(64), .PREFILL(16), .RATE_DIV(4), .IDLE_TIMEOUT(32)) dut_a (
      .clk(clk), .rst_n(a_rst), .enable(a_en),
      .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready),
      .dac_i(a_dac_i), .dac_q(a_dac_q), .dac_valid(a_dac_valid),
      .underrun(a_underrun), .underrun_clr(a_clr), .underrun_count(a_cnt),
      .fifo_level(a_level), .active(a_active)
   );

   dac_sample_streamer #(.DEPTH(64), .PREFILL(5), .RATE_DIV(1), .IDLE_TIMEOUT(32)) dut_b (
      .clk(clk), .rst_n(b_rst), .enable(b_en),
      .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
      .dac_i(b_dac_i), .dac_q(b_dac_q), .dac_valid(b_dac_valid),
      .underrun(b_underrun), .underrun_clr(b_clr), .underrun_count(b_cnt),
      .fifo_level(b_level), .active(b_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [15:0] ei;
      logic [15:0] eq;
      n_total = 0; n_pass = 0; n_fail = 0;
      a_rst = 1'b1; a_en = 1'b0; a_tvalid = 1'b0; a_tdata = '0; a_clr = 1'b0;
      b_rst = 1'b1; b_en = 1'b0; b_tvalid = 1'b0; b_tdata = '0; b_clr = 1'b0;
      step();
      step();

      // Reset state.
      chk("rst_level", 32'(a_level), 32'd0);
      chk("rst_tready", 32'(a_tready), 32'd1);
      chk("rst_valid", 32'(a_dac_valid), 32'd0);
      chk("rst_dac_i", 32'(a_dac_i), 32'd0);
      chk("rst_underrun", 32'(a_underrun), 32'd0);
      chk("rst_count", 32'(a_cnt), 32'd0);
      chk("rst_active", 32'(a_active), 32'd0);
      a_rst = 1'b0;
      b_rst = 1'b0;
      step();

      // Prefill to 16, then stream at one sample per 4 clocks, ending in an underrun.
      a_en = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         ei = k[15:0];
         eq = -ei;
         a_tdata  = {ei, eq};
         a_tvalid = 1'b1;
         step();
      end
      a_tvalid = 1'b0;
      chk("t1_level16", 32'(a_level), 32'd16);
      chk("t1_not_yet_active", 32'(a_active), 32'd0);
      step();
      chk("t1_active", 32'(a_active), 32'd1);
      for (int k = 1; k <= 17; k++) begin
         step();
         ei = (k <= 16) ? k[15:0] : 16'd0;
         eq = -ei;
         chk("t1_valid", 32'(a_dac_valid), 32'd1);
         chk("t1_dac_i", 32'(a_dac_i), 32'(ei));
         chk("t1_dac_q", 32'(a_dac_q), 32'(eq));
         if (k <= 16) begin
            chk("t1_level", 32'(a_level), 32'(16 - k));
            for (int j = 0; j < 3; j++) begin
               step();
               chk("t1_gap_valid", 32'(a_dac_valid), 32'd0);
            end
         end
      end
      chk("t1_underrun", 32'(a_underrun), 32'd1);
      chk("t1_count", 32'(a_cnt), 32'd1);
      chk("t1_idle", 32'(a_active), 32'd0);

      // Three samples then silence: gap timer reaches 32 on the 32nd edge after the last accept,
      // the state flips on the edge after that.
      for (int k = 21; k <= 23; k++) begin
         ei = k[15:0];
         eq = -ei;
         a_tdata  = {ei, eq};
         a_tvalid = 1'b1;
         step();
      end
      a_tvalid = 1'b0;
      chk("t2_level3", 32'(a_level), 32'd3);
      for (int j = 0; j < 32; j++) step();
      chk("t2_wait_active", 32'(a_active), 32'd0);
      step();
      chk("t2_timeout_active", 32'(a_active), 32'd1);
      for (int k = 21; k <= 23; k++) begin
         step();
         ei = k[15:0];
         chk("t2_valid", 32'(a_dac_valid), 32'd1);
         chk("t2_dac_i", 32'(a_dac_i), 32'(ei));
         for (int j = 0; j < 3; j++) step();
      end
      // Clear lands on the same edge as the second underrun: set wins, count restarts at 1.
      a_clr = 1'b1;
      step();
      a_clr = 1'b0;
      chk("t5_zero_valid", 32'(a_dac_valid), 32'd1);
      chk("t5_zero_i", 32'(a_dac_i), 32'd0);
      chk("t5_underrun_set", 32'(a_underrun), 32'd1);
      chk("t5_count_one", 32'(a_cnt), 32'd1);
      chk("t5_idle", 32'(a_active), 32'd0);
      a_clr = 1'b1;
      step();
      a_clr = 1'b0;
      chk("t5_clr_flag", 32'(a_underrun), 32'd0);
      chk("t5_clr_count", 32'(a_cnt), 32'd0);

      // Fill to 64 with enable low; the 65th offer must be refused.
      a_en = 1'b0;
      for (int k = 0; k < 64; k++) begin
         a_tdata  = {16'(100 + k), 16'(k)};
         a_tvalid = 1'b1;
         step();
      end
      chk("t3_full_level", 32'(a_level), 32'd64);
      chk("t3_full_tready", 32'(a_tready), 32'd0);
      a_tdata = {16'hDEAD, 16'hBEEF};
      step();
      a_tvalid = 1'b0;
      chk("t3_no_65th", 32'(a_level), 32'd64);
      chk("t3_idle_no_output", 32'(a_dac_valid), 32'd0);
      a_en = 1'b1;
      step();
      step();
      chk("t3_active", 32'(a_active), 32'd1);
      for (int k = 0; k < 54; k++) begin
         step();
         chk("t3_valid", 32'(a_dac_valid), 32'd1);
         chk("t3_dac_i", 32'(a_dac_i), 32'(16'(100 + k)));
         chk("t3_dac_q", 32'(a_dac_q), 32'(16'(k)));
         for (int j = 0; j < 3; j++) step();
      end
      chk("t6_level10", 32'(a_level), 32'd10);
      chk("t6_tready_back", 32'(a_tready), 32'd1);

      // Reset on what would have been a tick edge.
      a_rst = 1'b1;
      step();
      a_rst = 1'b0;
      a_en  = 1'b0;
      chk("t6_level", 32'(a_level), 32'd0);
      chk("t6_valid", 32'(a_dac_valid), 32'd0);
      chk("t6_dac_i", 32'(a_dac_i), 32'd0);
      chk("t6_dac_q", 32'(a_dac_q), 32'd0);
      chk("t6_active", 32'(a_active), 32'd0);
      chk("t6_tready", 32'(a_tready), 32'd1);

      // RATE_DIV=1: preload 5, then feed one sample per clock to match the drain.
      for (int k = 0; k < 5; k++) begin
         b_tdata  = {16'(101 + k), 16'(k)};
         b_tvalid = 1'b1;
         step();
      end
      b_tvalid = 1'b0;
      chk("t4_preload", 32'(b_level), 32'd5);
      b_en = 1'b1;
      step();
      chk("t4_prefill", 32'(b_active), 32'd0);
      step();
      chk("t4_active", 32'(b_active), 32'd1);
      chk("t4_level_entry", 32'(b_level), 32'd5);
      b_tdata  = {16'(106), 16'(5)};
      b_tvalid = 1'b1;
      for (int n = 0; n < 12; n++) begin
         step();
         chk("t4_valid", 32'(b_dac_valid), 32'd1);
         chk("t4_dac_i", 32'(b_dac_i), 32'(16'(101 + n)));
         chk("t4_level", 32'(b_level), 32'd5);
         b_tdata = {16'(107 + n), 16'(6 + n)};
      end
      b_tvalid = 1'b0;
      b_en     = 1'b0;
      step();
      step();
      chk("t4_stopped", 32'(b_active), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
